// File: rtl/m_cycle_cpu.sv
`timescale 1ns/1ps
// m_cycle_cpu -- multi-cycle MIPS-subset core.
//
// Each instruction walks BOOT/FETCH/DECODE/EXEC/WB under a small FSM. The
// core owns its PC, IR and a 32 x DATA_W register file. Instruction memory is
// external and answers a req/ack handshake that may insert wait states.
//
// Parameters
//   DATA_W    register / ALU width (32 or 64)
//   PC_RESET  PC loaded on reset
// Ports
//   clock_i       rising-edge clock
//   reset_ni      asynchronous active-low reset
//   imem_req_o    fetch request, high exactly while in FETCH
//   imem_addr_o   byte address of the fetched word (= pc)
//   imem_ack_i    instruction valid; only looked at in FETCH
//   imem_rdata_i  instruction word, valid with imem_ack_i
//   halt_o        sticky, core stopped (illegal op or syscall)
//   illegal_o     sticky, halt came from an undecodable instruction
//   wb_en_o       register write this cycle (WB, destination != 0)
//   wb_num_o      destination register of that write
//   wb_data_o     data written
module m_cycle_cpu #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  output logic              imem_req_o,
  output logic [31:0]       imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              halt_o,
  output logic              illegal_o,
  output logic              wb_en_o,
  output logic [4:0]        wb_num_o,
  output logic [DATA_W-1:0] wb_data_o
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, alu_q;
  logic              halt_q, illegal_q;
  logic [DATA_W-1:0] gpr_q [32];

  // instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign target = ir_q[25:0];

  // ---------------------------------------------------------------- decode
  // IR is stable from DECODE through WB, so the decode is combinational off
  // IR rather than being latched separately.
  logic       dec_legal, dec_br, dec_j, dec_sys;
  logic [4:0] dst;

  always_comb begin
    dec_legal = 1'b1;
    dec_br    = 1'b0;
    dec_j     = 1'b0;
    dec_sys   = 1'b0;
    unique case (op)
      6'h00: begin
        unique case (funct)
          6'h00, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h2A: ;
          6'h0C:   dec_sys   = 1'b1;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h0D, 6'h0F: ;
      6'h04, 6'h05: dec_br    = 1'b1;
      6'h02:        dec_j     = 1'b1;
      default:      dec_legal = 1'b0;
    endcase
  end

  // R-type writes rd, I-type writes rt
  assign dst = (op == 6'h00) ? rd : rt;

  // ------------------------------------------------------------------- ALU
  logic [DATA_W-1:0] simm, zimm, luiv, alu_res;

  assign simm = DATA_W'($signed(imm));
  assign zimm = DATA_W'(imm);
  assign luiv = DATA_W'($signed({imm, 16'h0000}));

  always_comb begin
    alu_res = '0;
    unique case (op)
      6'h00: begin
        unique case (funct)
          6'h00:        alu_res = b_q << shamt;
          6'h20, 6'h21: alu_res = a_q + b_q;
          6'h22, 6'h23: alu_res = a_q - b_q;
          6'h24:        alu_res = a_q & b_q;
          6'h25:        alu_res = a_q | b_q;
          6'h26:        alu_res = a_q ^ b_q;
          6'h2A:        alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
          default:      alu_res = '0;
        endcase
      end
      6'h08, 6'h09: alu_res = a_q + simm;
      6'h0D:        alu_res = a_q | zimm;
      6'h0F:        alu_res = luiv;
      default:      alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------- PC next value
  logic [31:0] pc_plus4, br_off, pc_br, pc_j;
  logic        taken;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};
  assign taken    = (op == 6'h04) ? (a_q == b_q) : (a_q != b_q);
  assign pc_br    = taken ? (pc_plus4 + br_off) : pc_plus4;
  assign pc_j     = {pc_plus4[31:28], target, 2'b00};

  always_comb begin
    pc_d = pc_q;
    if (state_q == S_EXEC && dec_br) pc_d = pc_br;
    if (state_q == S_EXEC && dec_j)  pc_d = pc_j;
    if (state_q == S_WB)             pc_d = pc_plus4;
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_BOOT;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack_i) state_d = S_DECODE;
      S_DECODE: state_d = dec_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (dec_br || dec_j) state_d = S_FETCH;
        else if (dec_sys)    state_d = S_HALT;
        else                 state_d = S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_BOOT;
    endcase
  end

  always_comb begin
    imem_req_o = (state_q == S_FETCH);
    wb_en_o    = 1'b0;
    wb_num_o   = '0;
    wb_data_o  = '0;
    if (state_q == S_WB) begin
      wb_en_o   = (dst != 5'd0);
      wb_num_o  = dst;
      wb_data_o = alu_q;
    end
  end

  assign imem_addr_o = pc_q;
  assign halt_o      = halt_q;
  assign illegal_o   = illegal_q;

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (state_q == S_FETCH && imem_ack_i) ir_q <= imem_rdata_i;
      if (state_q == S_DECODE) begin
        a_q <= gpr_q[rs];
        b_q <= gpr_q[rt];
        if (!dec_legal) begin
          halt_q    <= 1'b1;
          illegal_q <= 1'b1;
        end
      end
      if (state_q == S_EXEC) begin
        alu_q <= alu_res;
        if (dec_sys) halt_q <= 1'b1;
      end
    end
  end

  // register file; $0 is never written so it always reads zero
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (state_q == S_WB && dst != 5'd0) begin
      gpr_q[dst] <= alu_q;
    end
  end

endmodule

// File: tb/tb_m_cycle_cpu.sv
`timescale 1ns/1ps
module tb_m_cycle_cpu;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst32_n, rst64_n, ack;
  logic [31:0] rdata;

  logic        req32, halt32, ill32, wen32;
  logic [31:0] addr32, wdata32;
  logic [4:0]  wnum32;
  logic        req64, halt64, ill64, wen64;
  logic [31:0] addr64;
  logic [63:0] wdata64;
  logic [4:0]  wnum64;

  m_cycle_cpu #(.DATA_W(32), .PC_RESET(32'h0000_3000)) u32 (
    .clock_i(clock), .reset_ni(rst32_n),
    .imem_req_o(req32), .imem_addr_o(addr32),
    .imem_ack_i(ack), .imem_rdata_i(rdata),
    .halt_o(halt32), .illegal_o(ill32),
    .wb_en_o(wen32), .wb_num_o(wnum32), .wb_data_o(wdata32));

  m_cycle_cpu #(.DATA_W(64), .PC_RESET(32'h0000_3000)) u64 (
    .clock_i(clock), .reset_ni(rst64_n),
    .imem_req_o(req64), .imem_addr_o(addr64),
    .imem_ack_i(ack), .imem_rdata_i(rdata),
    .halt_o(halt64), .illegal_o(ill64),
    .wb_en_o(wen64), .wb_num_o(wnum64), .wb_data_o(wdata64));

  // the instance under test in the current phase
  int          cur_w;
  logic        o_req, o_halt, o_ill, o_wen;
  logic [31:0] o_addr;
  logic [4:0]  o_wnum;
  logic [63:0] o_wdata;

  always_comb begin
    if (cur_w == 64) begin
      o_req = req64; o_halt = halt64; o_ill = ill64; o_wen = wen64;
      o_addr = addr64; o_wnum = wnum64; o_wdata = wdata64;
    end else begin
      o_req = req32; o_halt = halt32; o_ill = ill32; o_wen = wen32;
      o_addr = addr32; o_wnum = wnum32; o_wdata = {32'h0, wdata32};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s w=%0d obs=%0h exp=%0h", tag, cur_w, obs, exp);
    end
  endtask

  // ------------------------------------------------ architectural reference
  logic [63:0] m_gpr [32];
  logic [31:0] m_pc;
  logic [63:0] last_wd;

  function automatic logic [63:0] msk(input logic [63:0] v);
    return (cur_w == 32) ? {32'h0, v[31:0]} : v;
  endfunction
  function automatic logic [63:0] sx(input logic [63:0] v);
    return (cur_w == 32) ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // kind: 0 register op, 1 branch/jump, 2 syscall, 3 illegal
  task automatic model(input logic [31:0] w, output int kind, output logic [4:0] d,
                       output logic [63:0] res, output logic [31:0] npc);
    logic [63:0] a, b, simm;
    logic [15:0] im;
    im   = w[15:0];
    a    = m_gpr[w[25:21]];
    b    = m_gpr[w[20:16]];
    simm = {{48{im[15]}}, im};
    kind = 0; res = 0; d = w[20:16]; npc = m_pc + 32'd4;
    case (w[31:26])
      6'h00: begin
        d = w[15:11];
        case (w[5:0])
          6'h00: res = b << w[10:6];
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h2A: res = ($signed(sx(a)) < $signed(sx(b))) ? 64'd1 : 64'd0;
          6'h0C: kind = 2;
          default: kind = 3;
        endcase
      end
      6'h08, 6'h09: res = a + simm;
      6'h0D: res = a | {48'h0, im};
      6'h0F: res = {{32{im[15]}}, im, 16'h0};
      6'h04: begin kind = 1; if (a == b) npc = m_pc + 32'd4 + (simm[31:0] << 2); end
      6'h05: begin kind = 1; if (a != b) npc = m_pc + 32'd4 + (simm[31:0] << 2); end
      6'h02: begin kind = 1; npc = {npc[31:28], w[25:0], 2'b00}; end
      default: kind = 3;
    endcase
    res = msk(res);
  endtask

  function automatic logic [31:0] R(input logic [5:0] f, input logic [4:0] s, t, dd, sh);
    return {6'h00, s, t, dd, sh, f};
  endfunction
  function automatic logic [31:0] I(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  // ------------------------------------------------------------- sequences
  task automatic set_rst(input logic v);
    if (cur_w == 64) begin rst64_n = v; rst32_n = 1'b0; end
    else             begin rst32_n = v; rst64_n = 1'b0; end
  endtask

  // called at a negedge; leaves the bench at the first FETCH negedge
  task automatic do_reset();
    set_rst(1'b0);
    #1;
    chk("rst_req", o_req, 0);
    chk("rst_addr", o_addr, 32'h3000);
    chk("rst_halt", o_halt, 0);
    chk("rst_ill", o_ill, 0);
    chk("rst_wen", o_wen, 0);
    chk("rst_wnum", o_wnum, 0);
    chk("rst_wdata", o_wdata, 0);
    for (int i = 0; i < 32; i++) m_gpr[i] = 0;
    m_pc = 32'h3000;
    @(negedge clock);
    set_rst(1'b1);
    ack = 1'b1;                 // BOOT must not take an ack
    chk("boot_req", o_req, 0);
    @(negedge clock);
    chk("first_req", o_req, 1);
    chk("first_addr", o_addr, 32'h3000);
  endtask

  // starts at a FETCH negedge, ends at the DECODE negedge
  task automatic fetch(input logic [31:0] w, input int waits);
    for (int i = 0; i < waits; i++) begin
      ack = 1'b0; rdata = $urandom;
      @(negedge clock);
      chk("wait_req", o_req, 1);
      chk("wait_addr", o_addr, m_pc);
    end
    ack = 1'b1; rdata = w;
    @(negedge clock);
    ack = 1'($urandom_range(0, 1)); rdata = $urandom;
    chk("dec_req", o_req, 0);
  endtask

  task automatic halted(input logic exp_ill);
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1;
      chk("halt", o_halt, 1);
      chk("halt_ill", o_ill, exp_ill);
      chk("halt_req", o_req, 0);
      @(negedge clock);
    end
  endtask

  task automatic run(input logic [31:0] w, input int waits);
    int kind; logic [4:0] d; logic [63:0] res; logic [31:0] npc;
    model(w, kind, d, res, npc);
    fetch(w, waits);
    @(negedge clock);                       // EXEC, or HALT for illegal
    if (kind == 3) begin halted(1'b1); return; end
    chk("exe_req", o_req, 0);
    chk("exe_wen", o_wen, 0);
    chk("exe_halt", o_halt, 0);
    ack = 1'b1;
    @(negedge clock);
    if (kind == 1) begin
      chk("br_req", o_req, 1);
      chk("br_addr", o_addr, npc);
      m_pc = npc;
    end else if (kind == 2) begin
      halted(1'b0);
    end else begin
      chk("wb_en", o_wen, d != 0);
      if (d != 0) chk("wb_num", o_wnum, d);
      chk("wb_data", o_wdata, res);
      last_wd = o_wdata;
      if (d != 0) m_gpr[d] = res;
      ack = 1'($urandom_range(0, 1));
      @(negedge clock);
      m_pc = m_pc + 32'd4;
      chk("nxt_req", o_req, 1);
      chk("nxt_addr", o_addr, m_pc);
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0] s, t, dd, sh;
    logic [15:0] im;
    logic [31:0] r;
    s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7));
    dd = 5'($urandom_range(0, 7)); sh = 5'($urandom); im = 16'($urandom);
    r = $urandom;
    case ($urandom_range(0, 11))
      0:  return R(6'h00, s, t, dd, sh);
      1:  return R(r[0] ? 6'h21 : 6'h20, s, t, dd, 5'd0);
      2:  return R(r[0] ? 6'h23 : 6'h22, s, t, dd, 5'd0);
      3:  return R(6'h24, s, t, dd, 5'd0);
      4:  return R(6'h25, s, t, dd, 5'd0);
      5:  return R(6'h26, s, t, dd, 5'd0);
      6:  return R(6'h2A, s, t, dd, 5'd0);
      7:  return I(r[0] ? 6'h09 : 6'h08, s, t, im);
      8:  return I(6'h0D, s, t, im);
      9:  return I(6'h0F, 5'd0, t, im);
      10: return I(r[0] ? 6'h05 : 6'h04, s, t, im);
      default: return {6'h02, r[25:0]};
    endcase
  endfunction

  task automatic phase(input int w);
    logic [63:0] m3;
    cur_w = w;
    m3 = (w == 32) ? 64'h0000_0000_FFFF_FFFD : 64'hFFFF_FFFF_FFFF_FFFD;
    @(negedge clock);
    // basic program, zero-wait then three waits per fetch
    for (int wt = 0; wt <= 3; wt += 3) begin
      do_reset();
      run(I(6'h09, 0, 1, 16'd5), wt);       chk("p_addiu5", last_wd, 5);
      run(I(6'h09, 0, 2, 16'hFFFD), wt);    chk("p_addiu_m3", last_wd, m3);
      run(R(6'h21, 1, 2, 3, 0), wt);        chk("p_addu", last_wd, 2);
    end
    // branches and jump
    do_reset();
    run(I(6'h05, 0, 0, 16'd2), 0);         chk("bne_pc", o_addr, 32'h3004);
    run({6'h02, 26'h0C00}, 1);             chk("j_pc", o_addr, 32'h3000);
    run(I(6'h04, 0, 0, 16'd2), 2);         chk("beq_pc", o_addr, 32'h300C);
    // lui / slt / $0
    run(I(6'h0F, 0, 4, 16'h8000), 0);
    chk("lui", last_wd, (w == 32) ? 64'h8000_0000 : 64'hFFFF_FFFF_8000_0000);
    run(I(6'h09, 0, 5, 16'hFFFF), 0);
    run(I(6'h09, 0, 6, 16'h0001), 0);
    run(R(6'h2A, 5, 6, 7, 0), 0);          chk("slt", last_wd, 1);
    run(I(6'h09, 0, 0, 16'd7), 0);
    run(R(6'h21, 0, 0, 8, 0), 0);          chk("r0_zero", last_wd, 0);
    // reset in the middle of EXEC
    do_reset();
    run(I(6'h09, 0, 1, 16'd5), 0);
    fetch(R(6'h21, 1, 2, 3, 0), 0);
    @(negedge clock);
    do_reset();
    run(R(6'h21, 1, 0, 9, 0), 0);          chk("r1_cleared", last_wd, 0);
    // halts
    do_reset();
    run(32'hFC00_0000, 0);
    do_reset();
    run(R(6'h0C, 0, 0, 0, 0), 1);
    // random program
    do_reset();
    for (int i = 0; i < 60; i++) run(rnd_instr(), $urandom_range(0, 3));
    run(32'hFC00_0000, $urandom_range(0, 3));
  endtask

  initial begin
    cur_w = 32; ack = 1'b0; rdata = '0; rst32_n = 1'b0; rst64_n = 1'b0;
    last_wd = '0;
    phase(32);
    phase(64);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/m_cycle_cpu.md
# m_cycle_cpu

Parametrised multi-cycle MIPS-subset core: next generation of the single-cycle datapath, adding a fetch/decode/execute/writeback state machine, an instruction-memory request/acknowledge handshake with wait states, I-type and branch/jump instructions, and a halt/illegal-instruction mechanism. It owns its PC, instruction register, and register file, and exposes a writeback debug port for verification. It sits at the top of the CPU hierarchy with instruction memory external.

## Interface
- DATA_W, 32: register/ALU width. Legal values are 32 and 64 only.
- PC_RESET, 32'h0000_3000: PC value loaded on reset.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high exactly while in FETCH.
- imem_addr  out  32  byte address of the requested instruction (= pc).
- imem_ack  in  1  instruction valid this cycle; sampled only in FETCH.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- halt  out  1  sticky; core stopped.
- illegal  out  1  sticky; halt was caused by an undecodable instruction.
- wb_en  out  1  register write this cycle (WB state, destination ≠ 0).
- wb_num  out  5  destination register of that write.
- wb_data  out  DATA_W  data written.

## Operation
- Register file: 32 × DATA_W, two combinational read ports, one write port. Register 0 reads 0, and writes to it are dropped with wb_en=0.
- States: BOOT, FETCH, DECODE, EXEC, WB, HALT.
- BOOT: single cycle, then FETCH.
- FETCH: imem_req=1, imem_addr=pc. On an edge with imem_ack=1, latch ir=imem_rdata and go to DECODE; otherwise stay.
- DECODE: latch A=gpr[rs], B=gpr[rt]; decode the instruction. If it is illegal, set halt and illegal and go to HALT.
- EXEC: compute the result into alu_out.
  - beq/bne/j update pc and return to FETCH. There is no delay slot.
  - syscall (funct 0x0C) sets halt and goes to HALT.
  - All other instructions go to WB.
- WB: write alu_out to the destination register, set pc=pc+4, go to FETCH.
- HALT: absorbing state. Outputs imem_req=0. Only reset leaves it.
- R-type (op 0x00), destination rd, by funct:
  - 0x00 sll: B<<shamt.
  - 0x20/0x21 add/addu: A+B, wrapping, no overflow trap.
  - 0x22/0x23 sub/subu: A−B.
  - 0x24 and, 0x25 or, 0x26 xor.
  - 0x2A slt: signed A<B gives 1, else 0.
- I-type, destination rt, by opcode:
  - 0x08/0x09 addi/addiu: A+sext(imm).
  - 0x0D ori: A|zext(imm).
  - 0x0F lui: sext({imm,16'h0}) to DATA_W.
- Branch/jump:
  - 0x04 beq, 0x05 bne: when taken, pc=pc+4+(sext(imm)<<2); otherwise pc=pc+4.
  - 0x02 j: pc={pc_plus4[31:28], target, 2'b00}.
- Any other opcode or funct is illegal.
- All arithmetic is modulo 2^DATA_W. PC arithmetic is modulo 2^32; pc wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset (reset=0), asynchronous:
  - state=BOOT, pc=PC_RESET, all registers 0, ir=0.
  - Outputs: imem_req=0, imem_addr=PC_RESET, halt=0, illegal=0, wb_en=0, wb_num=0, wb_data=0.
- Reset asserted mid-instruction aborts it immediately. No partial writeback occurs.
- Cycles per instruction with zero-wait ack (ack in the first FETCH cycle):
  - ALU ops: 4 (FETCH, DECODE, EXEC, WB).
  - beq/bne/j: 3.
  - Each cycle of ack=0 in FETCH adds 1.
- First imem_req=1 is on the cycle after the first post-reset edge (BOOT).
- imem_ack outside FETCH is ignored. Ack held high across consecutive fetches is legal: each FETCH consumes one cycle.
- imem_addr is stable for the whole FETCH dwell.
- wb_en/wb_num/wb_data are combinational from WB-state registers, valid only in WB. The register array updates on the edge ending WB.
- A DECODE read of a register written in the previous instruction's WB returns the new value. No hazards are possible.
- halt and illegal rise on the edge leaving DECODE/EXEC, never glitch, and clear only on reset.

## Test plan
- Reset then ack held 1; program addiu $1,$0,5 / addiu $2,$0,-3 / addu $3,$1,$2 → wb_data 5, 0xFFFF_FFFD, 2. Retirements 4 cycles apart. First imem_addr=0x3000.
- Fetch with 3 ack=0 cycles on each fetch → identical results; each instruction takes 7 cycles; imem_addr held steady.
- beq $0,$0,+2 at 0x3000 → next imem_addr 0x300C, no wb_en. bne $0,$0,+2 → next 0x3004. j 0x0C00 at 0x3004 → next 0x3000.
- lui $4,0x8000 with DATA_W=64 → wb_data 0xFFFF_FFFF_8000_0000. slt with 0xFFFF_FFFF vs 1 → 1. addiu $0,$0,7 → wb_en=0 and $0 stays 0.
- Word 0xFC000000 → halt=1, illegal=1, imem_req=0 permanently. syscall → halt=1, illegal=0.
- reset pulsed low during EXEC of addu $3 → no WB; pc=0x3000; $1 reads 0 after restart.
